// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller: FSM state encoding, instruction
// class constants, writeback-mux select codes and sign-extension helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_EXEC   = 3'd5,
    S_WR_C   = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction field extraction and immediate sign extension.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sext8(ir[7:0]);
  assign sximm5 = sext5(ir[4:0]);

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control unit: instruction register plus a Moore FSM that
// sequences register-file reads, ALU execution and writeback strobes.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;

  instr_dec u_dec (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  // IR only accepts a new word while idle, so a running instruction is stable.
  always_comb begin
    ir_d = ir_q;
    if (load && (state_q == S_WAIT)) begin
      ir_d = in;
    end else begin
      ir_d = ir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
        else   state_d = S_WAIT;
      end
      S_DECODE: begin
        if ((opcode == OPC_MOV) && (op == OP_MOV_IMM))      state_d = S_WR_IMM;
        else if ((opcode == OPC_MOV) && (op == OP_MOV_REG)) state_d = S_GET_B;
        else if ((opcode == OPC_ALU) && (op == OP_MVN))     state_d = S_GET_B;
        else if (opcode == OPC_ALU)                         state_d = S_GET_A;
        else                                                state_d = S_WAIT;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        bsel  = 1'b0;
        // MOV reg passes B through the ALU as 0 + B.
        if (opcode == OPC_ALU) begin
          ALUop = op;
          asel  = 1'b0;
        end else begin
          ALUop = 2'b00;
          asel  = 1'b1;
        end
        if ((opcode == OPC_ALU) && (op == OP_CMP)) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WR_C;
        end
      end
      S_WR_C: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected per-cycle output records are
// queued at issue time and a negedge monitor pops and compares them.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load, s;
  logic        w, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .write(write), .asel(asel), .bsel(bsel),
    .vsel(vsel), .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sx8, sx5;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] model_ir;
  bit          mon_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference: an idle cycle shows only w=1 and the immediates of the held IR.
  function automatic rec_t base_rec(input logic [15:0] ir, input logic idle);
    rec_t r;
    int v8, v5;
    r = '0;
    r.w = idle;
    v8 = int'(ir) % 256;
    if (v8 >= 128) v8 = v8 - 256;
    v5 = int'(ir) % 32;
    if (v5 >= 16) v5 = v5 - 32;
    r.sx8 = 16'(v8);
    r.sx5 = 16'(v5);
    return r;
  endfunction

  // Reference: the sequence of busy-cycle outputs an instruction produces.
  task automatic push_expected(input logic [15:0] ir);
    int opc, opv, rn, rd, sh, rm;
    rec_t r;
    opc = (int'(ir) / 8192) % 8;
    opv = (int'(ir) / 2048) % 4;
    rn  = (int'(ir) / 256) % 8;
    rd  = (int'(ir) / 32) % 8;
    sh  = (int'(ir) / 8) % 4;
    rm  = int'(ir) % 8;
    exp_q.push_back(base_rec(ir, 1'b0));
    if (opc == 6 && opv == 2) begin
      r = base_rec(ir, 1'b0);
      r.writenum = 3'(rn); r.vsel = 2'd1; r.write = 1'b1;
      exp_q.push_back(r);
    end else if ((opc == 6 && opv == 0) || opc == 5) begin
      if (opc == 5 && opv != 3) begin
        r = base_rec(ir, 1'b0);
        r.readnum = 3'(rn); r.loada = 1'b1;
        exp_q.push_back(r);
      end
      r = base_rec(ir, 1'b0);
      r.readnum = 3'(rm); r.loadb = 1'b1;
      exp_q.push_back(r);
      r = base_rec(ir, 1'b0);
      r.shift = 2'(sh);
      r.aluop = (opc == 5) ? 2'(opv) : 2'd0;
      r.asel  = (opc == 6);
      if (opc == 5 && opv == 1) r.loads = 1'b1;
      else                      r.loadc = 1'b1;
      exp_q.push_back(r);
      if (!(opc == 5 && opv == 1)) begin
        r = base_rec(ir, 1'b0);
        r.writenum = 3'(rd); r.vsel = 2'd3; r.write = 1'b1;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic check(input string name, input rec_t act, input rec_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (ir %h)", name, act, exp, model_ir);
    end
  endtask

  // Monitor: every cycle is either idle (checked against the held IR) or busy
  // (checked against the next queued record).
  always @(negedge clk) begin
    rec_t act;
    if (mon_en) begin
      act = {w, readnum, writenum, loada, loadb, loadc, loads, write, asel, bsel,
             vsel, shift, ALUop, sximm8, sximm5};
      if (w === 1'b1) begin
        if (exp_q.size() != 0) begin
          vectors++;
          miscompares++;
          $display("FAIL early_idle: got w=1 with %0d busy cycles still expected", exp_q.size());
          exp_q.delete();
        end
        check("idle", act, base_rec(model_ir, 1'b1));
      end else if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL late_idle: got busy %h expected w=1", act);
      end else begin
        check("busy", act, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(w === 1'b1 && exp_q.size() == 0) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got w=%b expected w=1 within 20 cycles", w);
      exp_q.delete();
    end
  endtask

  // Start an instruction; optionally poke load/s on the next (busy) edge.
  task automatic issue(input logic [15:0] ir, input bit with_load, input bit disturb);
    if (with_load) in = ir;
    load = with_load;
    s = 1'b1;
    @(posedge clk); #1;
    if (with_load) model_ir = ir;
    push_expected(model_ir);
    if (disturb) begin
      in = 16'($urandom);
      load = 1'b1;
      s = 1'b1;
    end else begin
      load = 1'b0;
      s = 1'b0;
    end
    @(posedge clk); #1;
    load = 1'b0;
    s = 1'b0;
    wait_idle();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [10:0] lo;
    lo = 11'($urandom);
    case ($urandom_range(0, 6))
      0:       return {3'b110, 2'b10, lo};
      1:       return {3'b110, 2'b00, lo};
      2:       return {3'b101, 2'b00, lo};
      3:       return {3'b101, 2'b01, lo};
      4:       return {3'b101, 2'b10, lo};
      5:       return {3'b101, 2'b11, lo};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in = 16'hD2FF; load = 1'b1; s = 1'b1;
    model_ir = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; load = 1'b0; s = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    issue(16'hD107, 1'b1, 1'b0);
    issue(16'hD2FF, 1'b1, 1'b1);
    issue(16'hA162, 1'b1, 1'b0);
    issue(16'hA902, 1'b1, 1'b1);
    issue(16'hE000, 1'b1, 1'b1);

    // Load first, start later with s alone.
    in = 16'hB862; load = 1'b1;
    @(posedge clk); #1;
    model_ir = 16'hB862; load = 1'b0;
    issue(16'h0000, 1'b0, 1'b0);

    // Reset during GET_B of an ADD, with load and s also asserted.
    in = 16'hA162; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    model_ir = 16'hA162;
    push_expected(model_ir);
    load = 1'b0; s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0; in = 16'hD2FF; load = 1'b1; s = 1'b1;
    exp_q.delete();
    model_ir = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1; load = 1'b0; s = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      issue(rand_instr(), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end

    repeat (2) @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
